// File: rtl/pipe_event_monitor.sv
// Pipeline event monitor: counts RUN cycles, stalls and flushes and exposes them through a registered readout port.
// Optional flush-PC trace buffer compiled in with `define PIPE_MON_TRACE_EN.
module pipe_event_monitor #(
  parameter int MAX_CYCLES = 64,
  parameter int CNT_W      = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic        branch_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic [4:0]  rd_addr_i,
  output logic [31:0] rd_data_o,
  output logic        running_o,
  output logic        done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Compare at a width that can hold both the counter and the limit so small CNT_W never truncates it.
  localparam int                 CMP_W      = (CNT_W > 32) ? CNT_W : 32;
  localparam logic [CMP_W-1:0]   LAST_CYCLE = CMP_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cycle_cnt, cycle_nxt;
  logic [CNT_W-1:0]  stall_cnt, stall_nxt;
  logic [CNT_W-1:0]  flush_cnt, flush_nxt;
  logic [31:0]       last_pc, last_pc_nxt;
  logic [31:0]       rd_nxt;
  logic              active;
  logic              count_stall;
  logic              count_flush;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [31:0] ext32(input logic [CNT_W-1:0] v);
    return 32'(v);
  endfunction

  always_comb begin
    state_nxt = state;
    active    = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) state_nxt = RUN;
      end
      RUN: begin
        if (!start_i) begin
          state_nxt = IDLE;
        end else begin
          active = 1'b1;
          if (CMP_W'(cycle_cnt) == LAST_CYCLE) state_nxt = DONE;
        end
      end
      DONE: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase

    count_stall = active && stall_i && !jump_i && !branch_i;
    count_flush = active && flush_i;
    cycle_nxt   = active      ? sat_inc(cycle_cnt) : cycle_cnt;
    stall_nxt   = count_stall ? sat_inc(stall_cnt) : stall_cnt;
    flush_nxt   = count_flush ? sat_inc(flush_cnt) : flush_cnt;
    last_pc_nxt = active      ? pc_i : last_pc;
  end

`ifdef PIPE_MON_TRACE_EN
  logic [31:0] trace [8];
  logic [2:0]  wptr;
  logic [3:0]  trace_cnt, trace_cnt_nxt;

  always_comb begin
    trace_cnt_nxt = trace_cnt;
    if (count_flush && trace_cnt != 4'd8) trace_cnt_nxt = trace_cnt + 4'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wptr      <= 3'd0;
      trace_cnt <= 4'd0;
      for (int k = 0; k < 8; k++) trace[k] <= 32'd0;
    end else begin
      trace_cnt <= trace_cnt_nxt;
      if (count_flush) begin
        trace[wptr] <= pc_i;
        wptr        <= wptr + 3'd1;
      end
    end
  end
`endif

  // Readout is built from the next-state values so the port shows what the counters hold after this edge.
  always_comb begin
    rd_nxt = 32'd0;
    case (rd_addr_i)
      5'd0: rd_nxt = ext32(cycle_nxt);
      5'd1: rd_nxt = ext32(stall_nxt);
      5'd2: rd_nxt = ext32(flush_nxt);
      5'd3: rd_nxt = {30'd0, state_nxt};
      5'd4: rd_nxt = last_pc_nxt;
      default: rd_nxt = 32'd0;
    endcase
`ifdef PIPE_MON_TRACE_EN
    if (rd_addr_i == 5'd5) rd_nxt = {28'd0, trace_cnt_nxt};
    if (rd_addr_i[4:3] == 2'b01) begin
      if (count_flush && wptr == rd_addr_i[2:0]) rd_nxt = pc_i;
      else rd_nxt = trace[rd_addr_i[2:0]];
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      last_pc   <= 32'd0;
      rd_data_o <= 32'd0;
      running_o <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cycle_cnt <= cycle_nxt;
      stall_cnt <= stall_nxt;
      flush_cnt <= flush_nxt;
      last_pc   <= last_pc_nxt;
      rd_data_o <= rd_nxt;
      running_o <= (state_nxt == RUN);
      done_o    <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_pipe_event_monitor.sv
// Directed testbench for pipe_event_monitor; a second small-width instance exercises counter saturation.
module tb_pipe_event_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stall, jump, branch, flush;
  logic [31:0] pc;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        running, done;

  logic        sat_start, sat_flush;
  logic [4:0]  sat_rd_addr;
  logic [31:0] sat_rd_data;
  logic        sat_running, sat_done;

  int errors = 0;
  int checks = 0;
  int n;

  always #5 clk = ~clk;

  pipe_event_monitor dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .stall_i  (stall),
    .jump_i   (jump),
    .branch_i (branch),
    .flush_i  (flush),
    .pc_i     (pc),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data),
    .running_o(running),
    .done_o   (done)
  );

  // 3-bit counters with a limit they can never reach, so only saturation is visible.
  pipe_event_monitor #(.MAX_CYCLES(20), .CNT_W(3)) sat_dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (sat_start),
    .stall_i  (1'b0),
    .jump_i   (1'b0),
    .branch_i (1'b0),
    .flush_i  (sat_flush),
    .pc_i     (32'h0),
    .rd_addr_i(sat_rd_addr),
    .rd_data_o(sat_rd_data),
    .running_o(sat_running),
    .done_o   (sat_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic st, input logic j, input logic b,
                               input logic f, input logic [31:0] p, input logic [4:0] a);
    start   = s;
    stall   = st;
    jump    = j;
    branch  = b;
    flush   = f;
    pc      = p;
    rd_addr = a;
    step();
  endtask

  task automatic readReg(input logic [4:0] a, input logic [31:0] exp, input string tag);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, a);
    checkOutput(tag, rd_data, exp);
  endtask

  initial begin
    rst = 1'b0;
    start = 0; stall = 0; jump = 0; branch = 0; flush = 0; pc = 0; rd_addr = 0;
    sat_start = 0; sat_flush = 0; sat_rd_addr = 0;
    step();
    step();
    checkOutput("rst_running", {31'd0, running}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_rd", rd_data, 32'd0);
    rst = 1'b1;
    readReg(5'd3, 32'd0, "idle_state");

    // Events: stalls masked by branch/jump, simultaneous stall+flush, post-update readout
    applyStimulus(1, 0, 0, 0, 0, 32'h0, 5'd0);
    checkOutput("run_entry", {31'd0, running}, 32'd1);
    checkOutput("entry_cycle", rd_data, 32'd0);
    applyStimulus(1, 1, 0, 0, 0, 32'h0, 5'd1);
    checkOutput("stall_first", rd_data, 32'd1);
    applyStimulus(1, 1, 0, 1, 0, 32'h0, 5'd1);
    checkOutput("branch_masks_stall", rd_data, 32'd1);
    applyStimulus(1, 1, 0, 0, 0, 32'h0, 5'd1);
    checkOutput("stall_cnt", rd_data, 32'd2);
    applyStimulus(1, 1, 0, 0, 1, 32'h1C, 5'd1);
    checkOutput("stall_flush_s", rd_data, 32'd3);
    applyStimulus(1, 0, 0, 0, 0, 32'h1C, 5'd2);
    checkOutput("stall_flush_f", rd_data, 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 32'h1C, 5'd4);
    checkOutput("last_pc", rd_data, 32'h1C);
    applyStimulus(1, 1, 1, 0, 0, 32'h1C, 5'd1);
    checkOutput("jump_masks_stall", rd_data, 32'd3);

    // Pause for 5 cycles: cycle count frozen at 7
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 32'h1C, 5'd0);
      checkOutput("pause_running", {31'd0, running}, 32'd0);
      checkOutput("pause_cycle", rd_data, 32'd7);
    end
    applyStimulus(1, 0, 0, 0, 0, 32'h1C, 5'd0);
    checkOutput("resume_running", {31'd0, running}, 32'd1);
    checkOutput("resume_cycle", rd_data, 32'd7);

    n = 0;
    while (!done && n < 200) begin
      applyStimulus(1, 0, 0, 0, 0, 32'h1C, 5'd0);
      n++;
    end
    checkOutput("edges_to_done", n, 32'd57);
    checkOutput("done_flag", {31'd0, done}, 32'd1);
    checkOutput("done_running", {31'd0, running}, 32'd0);
    checkOutput("done_cycle", rd_data, 32'd64);

    // DONE ignores start and events
    applyStimulus(1, 1, 0, 0, 1, 32'h40, 5'd1);
    checkOutput("done_ignores_stall", rd_data, 32'd3);
    applyStimulus(0, 0, 0, 0, 1, 32'h40, 5'd2);
    checkOutput("done_ignores_flush", rd_data, 32'd1);
    readReg(5'd3, 32'd2, "done_state");
    readReg(5'd0, 32'd64, "done_cycle_hold");
    readReg(5'd4, 32'h1C, "done_pc_hold");
    checkOutput("done_sticky", {31'd0, done}, 32'd1);

    // Reset out of DONE wins over an active start
    rst = 1'b0;
    applyStimulus(1, 1, 0, 0, 1, 32'h40, 5'd0);
    checkOutput("rst_done_flag", {31'd0, done}, 32'd0);
    checkOutput("rst_done_running", {31'd0, running}, 32'd0);
    checkOutput("rst_done_rd", rd_data, 32'd0);
    rst = 1'b1;
    for (int a = 0; a < 16; a++) readReg(5'(a), 32'd0, $sformatf("rst_addr%0d", a));

    // Ten flushes at PCs 4..40
    applyStimulus(1, 0, 0, 0, 0, 32'h0, 5'd0);
    for (int k = 1; k <= 10; k++) applyStimulus(1, 0, 0, 0, 1, 32'(4 * k), 5'd2);
    checkOutput("flush_cnt10", rd_data, 32'd10);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 5'd0);
`ifdef PIPE_MON_TRACE_EN
    readReg(5'd5, 32'd8, "trace_cnt");
    readReg(5'd8, 32'd36, "trace0");
    readReg(5'd9, 32'd40, "trace1");
    readReg(5'd10, 32'd12, "trace2");
    readReg(5'd15, 32'd32, "trace7");
`else
    readReg(5'd5, 32'd0, "no_trace_cnt");
    readReg(5'd8, 32'd0, "no_trace0");
    readReg(5'd9, 32'd0, "no_trace1");
`endif
    readReg(5'd6, 32'd0, "unmapped6");
    readReg(5'd16, 32'd0, "unmapped16");

    // Exact 64-cycle run from reset with no events
    rst = 1'b0;
    step();
    rst = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 32'h0, 5'd0);
    for (int i = 0; i < 63; i++) applyStimulus(1, 0, 0, 0, 0, 32'h0, 5'd0);
    checkOutput("not_done_63", {31'd0, done}, 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 32'h0, 5'd0);
    checkOutput("done_at_64", {31'd0, done}, 32'd1);
    readReg(5'd0, 32'd64, "run64_cycle");
    readReg(5'd3, 32'd2, "run64_state");

    // Saturation on the narrow instance
    sat_start = 1'b1;
    sat_flush = 1'b1;
    sat_rd_addr = 5'd2;
    for (int i = 0; i < 12; i++) step();
    checkOutput("sat_flush", sat_rd_data, 32'd7);
    checkOutput("sat_running", {31'd0, sat_running}, 32'd1);
    checkOutput("sat_not_done", {31'd0, sat_done}, 32'd0);
    sat_rd_addr = 5'd0;
    step();
    checkOutput("sat_cycle", sat_rd_data, 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_event_monitor.md
PIPE_EVENT_MONITOR -- requirements
Module: pipe_event_monitor

Interface
REQ-001 Parameter MAX_CYCLES, default 64: number of RUN cycles after which monitoring ends.
REQ-002 Parameter CNT_W, default 32: width of every event counter.
REQ-003 Clock and reset: one clock; reset is synchronous and active-low.
REQ-004 clk_i  input  1  clock; all state changes on its rising edge.
REQ-005 rst_i  input  1  synchronous active-low reset.
REQ-006 start_i  input  1  CPU start; high = CPU running.
REQ-007 stall_i  input  1  raw hazard-unit stall (PC/IF-ID hold).
REQ-008 jump_i  input  1  jump decoded in ID.
REQ-009 branch_i  input  1  branch decoded in ID.
REQ-010 flush_i  input  1  IF/ID flush request.
REQ-011 pc_i  input  32  current PC register value.
REQ-012 rd_addr_i  input  5  readout register select.
REQ-013 rd_data_o  output  32  registered readout data.
REQ-014 running_o  output  1  high while in RUN.
REQ-015 done_o  output  1  high in DONE; the bench finishes on it.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 IDLE->RUN SHALL occur on a rising edge where start_i=1.
REQ-018 RUN->IDLE SHALL occur when start_i=0 (pause); all counters hold.
REQ-019 In RUN, if cycle_cnt==MAX_CYCLES-1, the FSM SHALL go to DONE and still count that cycle.
REQ-020 DONE SHALL hold until reset, ignoring start_i and all event inputs.
REQ-021 In RUN, cycle_cnt SHALL increment by 1 every cycle.
REQ-022 stall_cnt SHALL increment in RUN when stall_i=1 and jump_i=0 and branch_i=0.
REQ-023 flush_cnt SHALL increment in RUN when flush_i=1.
REQ-024 A simultaneous stall and flush in one cycle SHALL increment both counters.
REQ-025 Counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-026 last_pc SHALL capture pc_i every RUN cycle.
REQ-027 Readout map, zero-extended to 32 bits: 0 = cycle_cnt; 1 = stall_cnt; 2 = flush_cnt; 3 = {30'b0, state[1:0]} with IDLE=0, RUN=1, DONE=2; 4 = last_pc; 5 = trace_cnt; 8-15 = trace entries; all other addresses read 0.
REQ-028 rd_data_o SHALL reflect rd_addr_i sampled on the previous edge (1-cycle latency), using post-update counter values from that edge.
REQ-029 running_o and done_o SHALL be registered decodes of the state.

Reset
REQ-030 With rst_i=0 at an edge: state=IDLE; all counters, last_pc, trace pointer, trace_cnt, trace entries and rd_data_o=0; running_o=0; done_o=0.
REQ-031 Reset SHALL take priority over every other event, including mid-RUN and in DONE.

Configuration
REQ-032 Macro PIPE_MON_TRACE_EN SHALL compile in the flush-PC trace buffer.
REQ-033 With PIPE_MON_TRACE_EN, every counted flush SHALL write pc_i into trace[wptr]; wptr (3 bits) SHALL advance and wrap 7->0.
REQ-034 With PIPE_MON_TRACE_EN, the oldest entry SHALL be overwritten when the buffer is full; trace_cnt SHALL saturate at 8.
REQ-035 With PIPE_MON_TRACE_EN, address 8+k SHALL return physical entry k.
REQ-036 Without PIPE_MON_TRACE_EN, no trace storage SHALL exist, and addresses 5 and 8-15 SHALL read 0.

Verification
REQ-037 Reset; start_i=1 for 64 cycles; no events -> done_o rises after the 64th RUN edge; addr0 reads 64; addr3 reads 2.
REQ-038 In RUN: 3 cycles stall_i=1, of which 1 has branch_i=1 -> addr1 reads 2.
REQ-039 In one RUN cycle: stall_i=1 and flush_i=1 with pc_i=0x1C -> addr1 +1, addr2 +1, addr4 reads 0x1C.
REQ-040 start_i dropped for 5 cycles mid-RUN -> addr0 unchanged across the gap; running_o=0 during the gap.
REQ-041 With PIPE_MON_TRACE_EN: 10 flushes at PCs 4,8,...,40 -> addr5 reads 8; addr8 reads 36; addr9 reads 40; addr10 reads 12.
REQ-042 rst_i=0 asserted while in DONE -> next edge: done_o=0, every readout address reads 0.
